// File: rtl/sqrt_core_if.sv
// Handshake/data bundle for sqrt_core: the requester drives start/radicand (master),
// the core drives result/remainder/done (slave).
interface sqrt_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] radicand;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  done;

    modport master (
        output start,
        output radicand,
        input  result,
        input  remainder,
        input  done
    );

    modport slave (
        input  start,
        input  radicand,
        output result,
        output remainder,
        output done
    );
endinterface

// File: rtl/sqrt_core.sv
// Restoring digit-recurrence integer square root, one result bit per cycle.
// Optional macro SQRT_CLZ_SKIP_EN skips leading zero bit pairs of the radicand to cut latency.
module sqrt_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    sqrt_core_if.slave  bus,
    output logic        dbg_state_o
);
    localparam int H  = DATA_WIDTH / 2;
    localparam int CW = $clog2(H + 1);

    // Handshake: start is taken in any cycle the core is IDLE (dbg_state_o == 0), with
    // radicand sampled in that same cycle; there is no back-pressure, a start seen while
    // BUSY is dropped. done is a single-cycle pulse, and result/remainder are valid from
    // that pulse until the next one.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] op_q, op_d;
    logic [H+1:0]          rem_w_q, rem_w_d;
    logic [H-1:0]          root_w_q, root_w_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         n_init;
    logic [DATA_WIDTH-1:0] op_init;

`ifdef SQRT_CLZ_SKIP_EN
    logic [CW-1:0] p_idx;
    int            shamt;

    // Highest nonzero pair decides how many iterations are really needed; the operand is
    // pre-shifted so that pair lands in the top position.
    always_comb begin
        p_idx = '0;
        for (int i = 0; i < H; i++) begin
            if (bus.radicand[2*i +: 2] != 2'b00) begin
                p_idx = CW'(i + 1);
            end
        end
        n_init  = (p_idx == '0) ? CW'(1) : p_idx;
        shamt   = 2 * (H - int'(n_init));
        op_init = bus.radicand << shamt;
    end
`else
    assign n_init  = CW'(H);
    assign op_init = bus.radicand;
`endif

    logic [1:0]   pair;
    logic [H+3:0] cat;
    logic [H+3:0] sub;
    logic [H+1:0] trial;
    logic         ge;
    logic [H+1:0] rem_step;
    logic [H-1:0] root_step;

    // One restoring step; the remainder stays below 2*root+1, so H+2 bits never overflow.
    always_comb begin
        pair      = op_q[DATA_WIDTH-1 -: 2];
        cat       = {rem_w_q, pair};
        sub       = {2'b00, root_w_q, 2'b01};
        ge        = (cat >= sub);
        trial     = cat[H+1:0] - sub[H+1:0];
        rem_step  = ge ? trial : cat[H+1:0];
        root_step = {root_w_q[H-2:0], ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rem_w_d     = rem_w_q;
        root_w_d    = root_w_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = op_init;
                    cnt_d    = n_init;
                    rem_w_d  = '0;
                    root_w_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                op_d     = op_q << 2;
                rem_w_d  = rem_step;
                root_w_d = root_step;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = DATA_WIDTH'(root_step);
                    remainder_d = DATA_WIDTH'(rem_step);
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rem_w_q     <= '0;
            root_w_q    <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rem_w_q     <= rem_w_d;
            root_w_q    <= root_w_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.done      = done_q;
    assign dbg_state_o   = (state_q == BUSY);

endmodule

// File: tb/tb_sqrt_core.sv
// Directed bench for sqrt_core (W=32): vector table plus protocol corner sequences;
// latency expectations follow SQRT_CLZ_SKIP_EN when it is defined.
module tb_sqrt_core;
    localparam int W = 32;

`ifdef SQRT_CLZ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    sqrt_core_if #(.DATA_WIDTH(W)) bus ();

    sqrt_core #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_rem = '0;

    typedef struct {
        logic [W-1:0] rad;
        logic [W-1:0] res;
        logic [W-1:0] rem;
        int           lat_skip;
    } vec_t;

    vec_t vecs[14];

    function automatic int exp_lat(input int lat_skip);
        return SKIP ? lat_skip : (W / 2 + 1);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (end of cycle 0).
    task automatic start_op(input logic [W-1:0] rad);
        bus.start    = 1'b1;
        bus.radicand = rad;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.radicand = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] res,
                             input logic [W-1:0] rem, input int lat);
        int cyc = 1;
        int hold_bad = 0;
        while (bus.done !== 1'b1 && cyc <= 60) begin
            if (bus.result !== last_res || bus.remainder !== last_rem) hold_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_done"}, W'(bus.done), W'(1));
        check({name, "_lat"}, W'(cyc), W'(lat));
        check({name, "_hold"}, W'(hold_bad), W'(0));
        check({name, "_res"}, bus.result, res);
        check({name, "_rem"}, bus.remainder, rem);
        last_res = res;
        last_rem = rem;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int pulse_cyc;
        int done_cnt;
        int done_cyc;
        int bad_out;

        vecs[0]  = '{32'd16,         32'd4,         32'd0,        4};
        vecs[1]  = '{32'd17,         32'd4,         32'd1,        4};
        vecs[2]  = '{32'hFFFF_FFFF,  32'h0000_FFFF, 32'h0001_FFFE, 17};
        vecs[3]  = '{32'h4000_0000,  32'h0000_8000, 32'd0,        17};
        vecs[4]  = '{32'd0,          32'd0,         32'd0,        2};
        vecs[5]  = '{32'd1,          32'd1,         32'd0,        2};
        vecs[6]  = '{32'd2,          32'd1,         32'd1,        2};
        vecs[7]  = '{32'd3,          32'd1,         32'd2,        2};
        vecs[8]  = '{32'd4,          32'd2,         32'd0,        3};
        vecs[9]  = '{32'd99,         32'd9,         32'd18,       5};
        vecs[10] = '{32'd1000000,    32'd1000,      32'd0,        11};
        vecs[11] = '{32'hFFFF_FFFE,  32'h0000_FFFF, 32'h0001_FFFD, 17};
        vecs[12] = '{32'd65536,      32'd256,       32'd0,        10};
        vecs[13] = '{32'd12345678,   32'd3513,      32'd4509,     13};

        bus.start    = 1'b0;
        bus.radicand = '0;
        rst_n        = 1'b0;

        // Reset, then idle with outputs held at zero.
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", W'(bus.done), W'(0));
        check("rst_res", bus.result, '0);
        check("rst_rem", bus.remainder, '0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_done", W'(bus.done), W'(0));
        check("idle_res", bus.result, '0);
        check("idle_state", W'(dbg_state), W'(0));

        foreach (vecs[i]) begin
            start_op(vecs[i].rad);
            wait_done($sformatf("vec%0d", i), vecs[i].res, vecs[i].rem, exp_lat(vecs[i].lat_skip));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse", i), W'(bus.done), W'(0));
        end

        // start while BUSY must be ignored; radicand scrambled after acceptance.
        bus.start    = 1'b1;
        bus.radicand = 32'd9;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.radicand = 32'd200;
        pulse_cyc = SKIP ? 2 : 5;
        done_cnt  = 0;
        done_cyc  = 0;
        for (int k = 1; k <= 25; k++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            bus.start = (k == pulse_cyc);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        check("busy_start_pulses", W'(done_cnt), W'(1));
        check("busy_start_lat", W'(done_cyc), W'(SKIP ? 3 : 17));
        check("busy_start_res", bus.result, 32'd3);
        check("busy_start_rem", bus.remainder, 32'd0);
        last_res = 32'd3;
        last_rem = 32'd0;

        // Back-to-back: new start in the done cycle.
        start_op(32'd16);
        wait_done("b2b_first", 32'd4, 32'd0, exp_lat(4));
        start_op(32'd100);
        wait_done("b2b_second", 32'd10, 32'd0, exp_lat(5));

        // Reset in cycle 8 of a long operation, with start held during reset.
        start_op(32'hFFFF_FFFF);
        repeat (7) @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.radicand = 32'd49;
        @(posedge clk);
        #1;
        check("midrst_done", W'(bus.done), W'(0));
        check("midrst_res", bus.result, '0);
        check("midrst_rem", bus.remainder, '0);
        check("midrst_state", W'(dbg_state), W'(0));
        rst_n     = 1'b1;
        bus.start = 1'b0;
        done_cnt  = 0;
        bad_out   = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.result !== '0 || bus.remainder !== '0) bad_out++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", W'(done_cnt), W'(0));
        check("midrst_outs_zero", W'(bad_out), W'(0));
        last_res = '0;
        last_rem = '0;
        start_op(32'd25);
        wait_done("after_rst", 32'd5, 32'd0, exp_lat(4));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
